seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Downstream consumer of the 7-segment prescaler's slow clock.
- Drives a 4-digit, common-anode, multiplexed 7-segment display from a 16-bit hex value.
- Advances one digit per rising edge of the slow clock and inserts a dead-time blank between digits to suppress ghosting.
- Snapshots the display data once per frame to avoid tearing.

Parameters:
- DEAD_CYCLES, 16, CLKIN cycles with all anodes off between digits (0 = no dead time).
- CNT_W, 8, width of the dead-time counter; DEAD_CYCLES must be < 2^CNT_W.

Ports:
- CLKIN  input  1  system clock (100 MHz)
- RSTN  input  1  asynchronous active-low reset
- SLOWCLK  input  1  prescaler output, a ~1 kHz square wave; asynchronous to this logic's sampling
- DATA  input  16  four hex nibbles; digit 0 = DATA[3:0], digit 3 = DATA[15:12]
- DP  input  4  decimal point request per digit, active-high
- AN  output  4  anode enables, active-low, registered
- SEG  output  7  {g,f,e,d,c,b,a}, active-low, registered
- DPOUT  output  1  decimal point, active-low, registered

Behaviour:
- Reset (RSTN low, asynchronous):
  - AN=4'b1111, SEG=7'b1111111, DPOUT=1.
  - state=IDLE, digit index=3, dead counter=0.
  - Shadow DATA/DP registers = 0. Sync flops = 0.
  - Reset may assert at any point and forces these values immediately. After release, the block waits in IDLE for a tick.
- Tick generation:
  - SLOWCLK passes through 2 sync flops, then a previous-value flop.
  - tick = sync2 & ~prev, one CLKIN cycle wide.
  - A SLOWCLK rising edge produces tick at the 3rd CLKIN edge after the edge is first sampled. SLOWCLK falling edges are ignored.
- States: IDLE, BLANK, SHOW.
  - IDLE --tick--> BLANK. Outputs stay at their reset values.
  - On any tick (from any state):
    - digit <= digit+1 mod 4 (3 wraps to 0).
    - dead counter <= DEAD_CYCLES.
    - state <= BLANK; AN <= 4'b1111 on the same edge.
  - Frame snapshot: when the new digit is 0, shadow_DATA <= DATA and shadow_DP <= DP on that edge. Changes to DATA/DP at any other time are not displayed until the next wrap to digit 0.
  - BLANK: AN=4'b1111, SEG=7'b1111111, DPOUT=1.
    - Counter decrements each cycle.
    - When it is 0 (and no tick this cycle), the next edge enters SHOW.
    - With DEAD_CYCLES=0, SHOW is entered on the edge after the tick. With DEAD_CYCLES=N, AN[digit] goes low N+1 edges after the tick edge.
  - BLANK interrupted by a tick: the blank restarts and the digit advances again (a skipped digit is acceptable).
  - SHOW:
    - AN = ~(4'b0001 << digit).
    - SEG = hex decode of the shadow nibble.
    - DPOUT = ~shadow_DP[digit].
    - Held until the next tick.
- Hex decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- At most one AN bit is low at any time. No cycle ever has two anodes active.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, digit k (k=3..1) is blanked (SEG=7'b1111111, DPOUT=1, anode still driven low) when the shadow nibble for digit k and every more-significant nibble are 0. Digit 0 is never blanked. The rule is evaluated on shadow data.
- Undefined: all digits always decoded. Zeros display as 1000000.

Test Plan:
- Reset, then toggle SLOWCLK -> before the first tick AN=1111, SEG=1111111, DPOUT=1. Assert RSTN low mid-SHOW -> outputs return to reset values with no clock edge.
- DATA=16'h1234, DP=4'b0000, DEAD_CYCLES=16, four SLOWCLK rises:
  - Digit 0 shows AN=1110, SEG=0011001 ('4'), 17 CLKIN edges after each tick.
  - Then AN=1101 '3' (0110000), AN=1011 '2' (0100100), AN=0111 '1' (1111001).
  - AN=1111 throughout each 16-cycle gap.
- Frame coherency: show digit 1 with DATA=16'h1234, change DATA to 16'hABCD -> digits 2 and 3 still show '2' and '1'. After the wrap to digit 0, SEG=0100001 ('d').
- DP=4'b0100, DATA=16'h8888 -> DPOUT=0 only while AN=1011; DPOUT=1 in BLANK and for other digits.
- DEAD_CYCLES=0 build -> AN goes from 1111 to the active pattern exactly one edge after tick. A SLOWCLK pulse spanning 5 CLKIN cycles produces exactly one tick.
- LEADING_ZERO_BLANK_EN defined, DATA=16'h0042 -> digits 3 and 2 show SEG=1111111; digit 1 shows '4', digit 0 shows '2'. DATA=16'h0000 -> only digit 0 shows '0'. Undefined: DATA=16'h0042 -> digits 3 and 2 show 1000000.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode multiplexed 7-segment driver.
// Advances one digit per rising edge of SLOWCLK and blanks all anodes for DEAD_CYCLES
// between digits. Display data is snapshotted on each wrap to digit 0.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 never blanked).
module seven_seg_scan #(
    parameter int unsigned DEAD_CYCLES = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        CLKIN,
    input  logic        RSTN,
    input  logic        SLOWCLK,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DPOUT
);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    localparam logic [CNT_W-1:0] DeadInit = CNT_W'(DEAD_CYCLES);

    logic             sync_1, sync_2, prev;
    logic             tick;
    state_e           state;
    logic [1:0]       digit;
    logic [1:0]       digit_nxt;
    logic [CNT_W-1:0] dead_cnt;
    logic [15:0]      shadow_data;
    logic [3:0]       shadow_dp;
    logic [3:0]       nibble;
    logic             lz_blank;
    logic [3:0]       show_an;
    logic [6:0]       show_seg;
    logic             show_dp;

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // SLOWCLK is asynchronous: two-flop synchroniser plus edge-detect history.
    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_1 <= SLOWCLK;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign tick      = sync_2 & ~prev;
    assign digit_nxt = digit + 2'd1;

    // Glyph for the current digit from shadow data; latched into the outputs on entering SHOW.
    always_comb begin
        nibble = shadow_data[{digit, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this nibble and all more-significant ones are zero.
        lz_blank = (digit != 2'd0) && ((shadow_data >> {digit, 2'b00}) == 16'd0);
`else
        lz_blank = 1'b0;
`endif
        show_an  = ~(4'b0001 << digit);
        show_seg = lz_blank ? 7'b1111111 : hex_decode(nibble);
        show_dp  = lz_blank ? 1'b1 : ~shadow_dp[digit];
    end

    // Scan FSM with registered display outputs; a tick restarts the blank from any state.
    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            state       <= StIdle;
            digit       <= 2'd3;
            dead_cnt    <= '0;
            shadow_data <= 16'd0;
            shadow_dp   <= 4'd0;
            AN          <= 4'b1111;
            SEG         <= 7'b1111111;
            DPOUT       <= 1'b1;
        end else if (tick) begin
            digit    <= digit_nxt;
            dead_cnt <= DeadInit;
            state    <= StBlank;
            AN       <= 4'b1111;
            SEG      <= 7'b1111111;
            DPOUT    <= 1'b1;
            if (digit_nxt == 2'd0) begin
                shadow_data <= DATA;
                shadow_dp   <= DP;
            end
        end else begin
            case (state)
                StBlank: begin
                    if (dead_cnt == '0) begin
                        state <= StShow;
                        AN    <= show_an;
                        SEG   <= show_seg;
                        DPOUT <= show_dp;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                StIdle, StShow: begin
                    state <= state;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: two instances (DEAD_CYCLES=16 and 0) compared every
// cycle against a behavioural model, plus literal checks of display sequences.
module tb_seven_seg_scan;

    logic        CLKIN = 1'b0;
    logic        RSTN;
    logic        SLOWCLK;
    logic [15:0] DATA;
    logic [3:0]  DP;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dpout0, dpout1;

    always #5 CLKIN = ~CLKIN;

    seven_seg_scan #(.DEAD_CYCLES(16), .CNT_W(8)) u_dut0 (
        .CLKIN(CLKIN), .RSTN(RSTN), .SLOWCLK(SLOWCLK), .DATA(DATA), .DP(DP),
        .AN(an0), .SEG(seg0), .DPOUT(dpout0)
    );

    seven_seg_scan #(.DEAD_CYCLES(0), .CNT_W(8)) u_dut1 (
        .CLKIN(CLKIN), .RSTN(RSTN), .SLOWCLK(SLOWCLK), .DATA(DATA), .DP(DP),
        .AN(an1), .SEG(seg1), .DPOUT(dpout1)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = 7'b1111111;
`else
    localparam logic [6:0] ZB = 7'b1000000;
`endif

    int tests = 0;
    int fails = 0;
    bit rand_data = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: SLOWCLK samples taken at the last three edges, per-instance scan position.
    bit          hist [3];
    bit          started [2];
    int          digit_m [2];
    int          since [2];
    logic [15:0] sh_data [2];
    logic [3:0]  sh_dp [2];
    logic [3:0]  rec0 [64];
    logic [3:0]  rec1 [64];

    function automatic int dead_of(input int i);
        return (i == 0) ? 16 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) hist[k] = 0;
        for (int i = 0; i < 2; i++) begin
            started[i] = 0;
            digit_m[i] = 3;
            since[i]   = 0;
            sh_data[i] = 16'd0;
            sh_dp[i]   = 4'd0;
        end
    endtask

    // A rise sampled at edge e-2 (and low at e-3) is acted on at edge e.
    task automatic model_edge();
        bit t;
        if (!RSTN) begin
            model_reset();
            return;
        end
        t = hist[1] && !hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = SLOWCLK;
        for (int i = 0; i < 2; i++) begin
            if (t) begin
                digit_m[i] = (digit_m[i] + 1) % 4;
                since[i]   = 0;
                started[i] = 1;
                if (digit_m[i] == 0) begin
                    sh_data[i] = DATA;
                    sh_dp[i]   = DP;
                end
            end else if (started[i] && since[i] < 100000) begin
                since[i]++;
            end
        end
    endtask

    function automatic bit m_show(input int i);
        return started[i] && (since[i] > dead_of(i));
    endfunction

    function automatic bit m_lz(input int i);
`ifdef LEADING_ZERO_BLANK_EN
        return (digit_m[i] != 0) && ((sh_data[i] >> (4 * digit_m[i])) == 16'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_an(input int i);
        logic [3:0] one;
        if (!m_show(i)) return 4'b1111;
        one = 4'b0001 << digit_m[i];
        return ~one;
    endfunction

    function automatic logic [6:0] exp_seg(input int i);
        logic [15:0] sh;
        if (!m_show(i) || m_lz(i)) return 7'b1111111;
        sh = sh_data[i] >> (4 * digit_m[i]);
        return hex_tab[sh[3:0]];
    endfunction

    function automatic logic exp_dp(input int i);
        if (!m_show(i) || m_lz(i)) return 1'b1;
        return ~sh_dp[i][digit_m[i]];
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic check_onehot(input string name, input logic [3:0] a);
        tests++;
        if ($countones(~a) > 1) begin
            fails++;
            $display("FAIL %s: got AN=%b, expected at most one low bit (t=%0t)", name, a, $time);
        end
    endtask

    task automatic check_all();
        check("an0", {3'b0, an0}, {3'b0, exp_an(0)});
        check("seg0", seg0, exp_seg(0));
        check("dp0", {6'b0, dpout0}, {6'b0, exp_dp(0)});
        check("an1", {3'b0, an1}, {3'b0, exp_an(1)});
        check("seg1", seg1, exp_seg(1));
        check("dp1", {6'b0, dpout1}, {6'b0, exp_dp(1)});
        check_onehot("onehot0", an0);
        check_onehot("onehot1", an1);
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string name, input logic [6:0] dut_v, input logic [6:0] mdl_v,
                       input logic [6:0] want);
        check({name, "_dut"}, dut_v, want);
        check({name, "_model"}, mdl_v, want);
    endtask

    task automatic lit_show(input string name, input logic [3:0] a, input logic [6:0] s,
                            input logic d);
        lit({name, "_an0"}, {3'b0, an0}, {3'b0, exp_an(0)}, {3'b0, a});
        lit({name, "_seg0"}, seg0, exp_seg(0), s);
        lit({name, "_dp0"}, {6'b0, dpout0}, {6'b0, exp_dp(0)}, {6'b0, d});
        lit({name, "_an1"}, {3'b0, an1}, {3'b0, exp_an(1)}, {3'b0, a});
    endtask

    task automatic step();
        @(posedge CLKIN);
        model_edge();
        #1;
        check_all();
        if (rand_data && $urandom_range(0, 7) == 0) begin
            DATA = 16'($urandom);
            DP   = 4'($urandom);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        for (int k = 0; k < hi + lo; k++) begin
            SLOWCLK = (k < hi);
            step();
            if (k < 64) begin
                rec0[k] = an0;
                rec1[k] = an1;
            end
        end
    endtask

    // Reset asserted between edges must clear the outputs with no clock edge.
    task automatic async_reset();
        #2 RSTN = 1'b0;
        #1 model_reset();
        lit_show("async_rst", 4'b1111, 7'b1111111, 1'b1);
        check_all();
        repeat (3) step();
        #2 RSTN = 1'b1;
    endtask

    initial begin
        RSTN    = 1'b0;
        SLOWCLK = 1'b0;
        DATA    = 16'h1234;
        DP      = 4'b0000;
        model_reset();
        repeat (2) @(posedge CLKIN);
        #1;
        lit_show("reset", 4'b1111, 7'b1111111, 1'b1);
        #2 RSTN = 1'b1;
        repeat (3) step();

        // First frame: latency of the first displayed digit for both dead times.
        pulse(5, 40);
        check("pre_tick_an0", {3'b0, rec0[1]}, 7'b0001111);
        check("lat16_blank", {3'b0, rec0[18]}, 7'b0001111);
        check("lat16_show", {3'b0, rec0[19]}, 7'b0001110);
        check("lat0_blank", {3'b0, rec1[2]}, 7'b0001111);
        check("lat0_show", {3'b0, rec1[3]}, 7'b0001110);
        lit_show("d0_4", 4'b1110, 7'b0011001, 1'b1);
        pulse(5, 40);
        lit_show("d1_3", 4'b1101, 7'b0110000, 1'b1);

        // Mid-frame data change must not show until the wrap to digit 0.
        DATA = 16'hABCD;
        pulse(5, 40);
        lit_show("d2_2", 4'b1011, 7'b0100100, 1'b1);
        pulse(5, 40);
        lit_show("d3_1", 4'b0111, 7'b1111001, 1'b1);
        pulse(5, 40);
        lit_show("d0_d", 4'b1110, 7'b0100001, 1'b1);

        DATA = 16'h8888;
        DP   = 4'b0100;
        pulse(5, 40);
        lit_show("d1_C", 4'b1101, 7'b1000110, 1'b1);
        pulse(5, 40);
        pulse(5, 40);
        pulse(5, 40);
        lit_show("dp_d0", 4'b1110, 7'b0000000, 1'b1);
        pulse(5, 40);
        lit_show("dp_d1", 4'b1101, 7'b0000000, 1'b1);
        pulse(5, 40);
        lit_show("dp_d2", 4'b1011, 7'b0000000, 1'b0);
        pulse(5, 40);
        lit_show("dp_d3", 4'b0111, 7'b0000000, 1'b1);

        // Leading zeros.
        DATA = 16'h0042;
        DP   = 4'b0000;
        pulse(5, 40);
        lit_show("lz_d0", 4'b1110, 7'b0100100, 1'b1);
        pulse(5, 40);
        lit_show("lz_d1", 4'b1101, 7'b0011001, 1'b1);
        pulse(5, 40);
        lit_show("lz_d2", 4'b1011, ZB, 1'b1);
        pulse(5, 40);
        lit_show("lz_d3", 4'b0111, ZB, 1'b1);
        DATA = 16'h0000;
        pulse(5, 40);
        lit_show("zero_d0", 4'b1110, 7'b1000000, 1'b1);
        pulse(5, 40);
        lit_show("zero_d1", 4'b1101, ZB, 1'b1);

        async_reset();
        DATA = 16'h5A5A;
        pulse(3, 30);
        lit_show("post_rst", 4'b1110, 7'b0001000, 1'b1);

        // Random slow-clock timing (including blank interruptions) and random data.
        rand_data = 1;
        repeat (60) pulse($urandom_range(1, 25), $urandom_range(1, 25));
        async_reset();
        repeat (10) pulse($urandom_range(1, 25), $urandom_range(1, 25));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
